road_phase_scheduler: RTL and testbench
=======================================

// Module: road_phase_scheduler
// PURPOSE
//   Schedules the shared intersection between the main highway and N_SIDE country-road approaches.
//   The main highway is green by default. Side approaches with a car waiting are served round-robin.
//   Every green-to-green change passes through a yellow phase and an all-red clearance.
//   Drives the 2-bit lamp codes consumed by the signal heads and the intersection monitor.
// PARAMETERS
//   N_SIDE          3   number of side approaches (2..4)
//   TW              8   phase timer width, bits
//   MAIN_MIN_GREEN 16   minimum main green, cycles
//   SIDE_MIN_GREEN  4   minimum side green, cycles
//   SIDE_MAX_GREEN 10   maximum side green, cycles
//   YELLOW_T        3   yellow duration, cycles
//   ALLRED_T        2   all-red clearance, cycles
// PORTS
//   CLK        in   1         rising-edge clock
//   CLEAR      in   1         asynchronous, active-low reset
//   CAR_ON     in   N_SIDE    per-approach car-present sensor, level; already synchronised upstream
//   MAIN_SIG   out  2         main highway lamp
//   SIDE_SIG   out  2*N_SIDE  side lamps; approach i uses bits [2i+1:2i]
//   GRANT_IDX  out  2         approach currently served; valid in SIDE_* and ALL_RED_2 states
//   PHASE      out  3         current state code, for debug
//   EMERG_REQ  in   1         (EMERG_PREEMPT_EN only) emergency preemption request, level
//   EMERG_IDX  in   3         (EMERG_PREEMPT_EN only) 0 = main, k = side approach k-1
// BEHAVIOUR
//   Lamp codes: RED=2'd0, YELLOW=2'd1, GREEN=2'd2. 2'd3 is never driven.
//   All outputs are registered and decoded from the state register. No combinational input-to-output path.
//   Reset (CLEAR=0), effective immediately:
//     state=MAIN_GREEN, timer=0, rr_ptr=0, GRANT_IDX=0.
//     MAIN_SIG=GREEN, SIDE_SIG=all RED, PHASE=0.
//   States and their PHASE codes:
//     MAIN_GREEN(0) -> MAIN_YELLOW(1) -> ALL_RED_1(2) -> SIDE_GREEN(3)
//     -> SIDE_YELLOW(4) -> ALL_RED_2(5) -> MAIN_GREEN.
//   The timer clears on every state entry and increments each cycle.
//   A state of duration D lasts exactly D cycles.
//   MAIN_GREEN exit condition: timer >= MAIN_MIN_GREEN-1 and |CAR_ON.
//     On exit, latch GRANT_IDX = first i with CAR_ON[i]=1, searching from rr_ptr upward with wrap.
//   MAIN_YELLOW lasts YELLOW_T cycles. ALL_RED_1 lasts ALLRED_T cycles.
//     Both are committed: a request dropping during them does not abort the sequence.
//   SIDE_GREEN for approach g:
//     Stay at least SIDE_MIN_GREEN cycles.
//     Then exit when CAR_ON[g]=0, or when SIDE_MAX_GREEN cycles have elapsed.
//     Requests on other approaches are ignored here.
//   SIDE_YELLOW lasts YELLOW_T cycles.
//   ALL_RED_2 lasts ALLRED_T cycles. On exit, rr_ptr = (g+1) mod N_SIDE.
//   Lamp decode:
//     MAIN_SIG is GREEN in MAIN_GREEN, YELLOW in MAIN_YELLOW, RED otherwise.
//     SIDE_SIG[g] is GREEN in SIDE_GREEN, YELLOW in SIDE_YELLOW, RED otherwise.
//   Safety invariant: at most one approach (main included) is non-RED in any cycle.
//   Timer saturates at 2^TW-1. Every duration parameter must be <= 2^TW-1 (elaboration check).
// CONFIGURATION
//   EMERG_PREEMPT_EN defined: EMERG_REQ/EMERG_IDX ports exist.
//     EMERG_REQ=1 with target not currently green:
//       a green phase goes to its yellow immediately (minimum green waived);
//       then all-red, then the target goes green.
//     Yellow and all-red phases already in progress complete before the target goes green.
//     The target holds green while EMERG_REQ=1.
//     On release: yellow, all-red, then MAIN_GREEN. rr_ptr is unchanged.
//   EMERG_PREEMPT_EN undefined: ports absent. Behaviour is exactly as above.
// STRUCTURE
//   Package road_sig_pkg holds:
//     lamp code constants RED/YELLOW/GREEN;
//     the phase state enum and its PHASE encodings;
//     the EMERG_IDX main-road code.
//   Sub-module side_rr_arbiter: combinational round-robin pick from CAR_ON and rr_ptr.
//     Outputs: valid, index.
// TESTING
//   1. CLEAR low, then CAR_ON=0 for 100 cycles
//      -> MAIN_SIG=2, SIDE_SIG all 0, PHASE=0 throughout.
//   2. CAR_ON=3'b010 held from reset release
//      -> main green 16 cycles, yellow 3, all-red 2;
//      -> SIDE_SIG[1]=GREEN exactly 10 cycles, then yellow 3, all-red 2;
//      -> then main green again.
//   3. CAR_ON=3'b111 held
//      -> successive side grants GRANT_IDX = 0, 1, 2, 0;
//      -> MAIN_GREEN lasts 16 cycles between each grant.
//   4. CAR_ON[2] pulsed 1 cycle at main-green cycle 20
//      -> the sequence is committed; SIDE_SIG[2]=GREEN exactly 4 cycles.
//   5. CLEAR driven low mid SIDE_GREEN (no clock edge)
//      -> MAIN_SIG=2 and SIDE_SIG=0 immediately; PHASE=0 after release.
//   6. (EMERG_PREEMPT_EN) EMERG_REQ=1 with EMERG_IDX=3 at main-green cycle 2
//      -> main yellow next cycle, then all-red;
//      -> SIDE_SIG[2]=GREEN until EMERG_REQ=0.
//   All runs: assert the safety invariant and MAIN_SIG/SIDE_SIG != 3 every cycle.

Source files
------------

// File: rtl/road_sig_pkg.sv
// Shared definitions for the road phase scheduler.
// Contents: lamp codes (RED/YELLOW/GREEN), the phase state enum whose
// encodings double as the PHASE debug code, the EMERG_IDX main-road code,
// and lamp decode helpers used by the scheduler output register.
package road_sig_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_2   = 3'd5
  } phase_t;

  localparam logic [2:0] EMERG_MAIN = 3'd0;

  function automatic logic [1:0] main_lamp(input phase_t s);
    case (s)
      MAIN_GREEN:  return GREEN;
      MAIN_YELLOW: return YELLOW;
      default:     return RED;
    endcase
  endfunction

  function automatic logic [1:0] side_lamp(input phase_t s);
    case (s)
      SIDE_GREEN:  return GREEN;
      SIDE_YELLOW: return YELLOW;
      default:     return RED;
    endcase
  endfunction

endpackage

// File: rtl/side_rr_arbiter.sv
// Combinational round-robin pick among side approaches.
// Ports:
//   car_on  in  N_SIDE  per-approach request
//   rr_ptr  in  2       approach with highest priority this round
//   valid   out 1       at least one request present
//   index   out 2       first requesting approach at or after rr_ptr (wrapping)
module side_rr_arbiter #(
  parameter int unsigned N_SIDE = 3
) (
  input  logic [N_SIDE-1:0] car_on,
  input  logic [1:0]        rr_ptr,
  output logic              valid,
  output logic [1:0]        index
);

  // Offset k from rr_ptr maps to approach c when rr_ptr+k == c or c+N_SIDE;
  // scanning k outermost gives priority in wrap order without a modulo.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int unsigned k = 0; k < N_SIDE; k++) begin
      for (int unsigned c = 0; c < N_SIDE; c++) begin
        if (!valid && car_on[c] &&
            ((32'(rr_ptr) + k == c) || (32'(rr_ptr) + k == c + N_SIDE))) begin
          valid = 1'b1;
          index = 2'(c);
        end
      end
    end
  end

endmodule

// File: rtl/road_phase_scheduler.sv
// Intersection phase scheduler: main highway green by default, side
// approaches with waiting cars served round-robin, every change of green
// passing through yellow and all-red clearance.
// Ports:
//   CLK        in   rising-edge clock
//   CLEAR      in   asynchronous active-low reset
//   CAR_ON     in   per-approach car-present sensors (synchronised upstream)
//   EMERG_REQ  in   emergency preemption request (EMERG_PREEMPT_EN only)
//   EMERG_IDX  in   preemption target, 0 = main, k = side k-1 (EMERG_PREEMPT_EN only)
//   MAIN_SIG   out  main highway lamp code
//   SIDE_SIG   out  side lamp codes, approach i at [2i+1:2i]
//   GRANT_IDX  out  approach being served
//   PHASE      out  current state code
// Build option: define EMERG_PREEMPT_EN to add emergency preemption.
// All outputs are registered from the next-state decode.
module road_phase_scheduler
  import road_sig_pkg::*;
#(
  parameter int unsigned N_SIDE         = 3,
  parameter int unsigned TW             = 8,
  parameter int unsigned MAIN_MIN_GREEN = 16,
  parameter int unsigned SIDE_MIN_GREEN = 4,
  parameter int unsigned SIDE_MAX_GREEN = 10,
  parameter int unsigned YELLOW_T       = 3,
  parameter int unsigned ALLRED_T       = 2
) (
  input  logic                CLK,
  input  logic                CLEAR,
  input  logic [N_SIDE-1:0]   CAR_ON,
`ifdef EMERG_PREEMPT_EN
  input  logic                EMERG_REQ,
  input  logic [2:0]          EMERG_IDX,
`endif
  output logic [1:0]          MAIN_SIG,
  output logic [2*N_SIDE-1:0] SIDE_SIG,
  output logic [1:0]          GRANT_IDX,
  output logic [2:0]          PHASE
);

  localparam longint unsigned TMAX = (64'd1 << TW) - 64'd1;

  if (N_SIDE < 2 || N_SIDE > 4) begin : g_bad_nside
    $error("N_SIDE must be 2..4");
  end
  if (TW < 2 || TW > 31) begin : g_bad_tw
    $error("TW must be 2..31");
  end
  if (MAIN_MIN_GREEN > TMAX || SIDE_MIN_GREEN > TMAX || SIDE_MAX_GREEN > TMAX ||
      YELLOW_T > TMAX || ALLRED_T > TMAX) begin : g_bad_dur
    $error("duration parameter exceeds timer range");
  end
  if (MAIN_MIN_GREEN < 1 || SIDE_MIN_GREEN < 1 || SIDE_MAX_GREEN < SIDE_MIN_GREEN ||
      YELLOW_T < 1 || ALLRED_T < 1) begin : g_bad_order
    $error("durations must be >= 1 and SIDE_MAX_GREEN >= SIDE_MIN_GREEN");
  end

  // Timer value seen in the last cycle of a phase of duration D is D-1.
  localparam logic [TW-1:0] MG_LAST  = TW'(MAIN_MIN_GREEN - 1);
  localparam logic [TW-1:0] SMN_LAST = TW'(SIDE_MIN_GREEN - 1);
  localparam logic [TW-1:0] SMX_LAST = TW'(SIDE_MAX_GREEN - 1);
  localparam logic [TW-1:0] Y_LAST   = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] AR_LAST  = TW'(ALLRED_T - 1);

  phase_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [1:0]    rr_ptr, rr_ptr_nxt, grant_nxt;
  logic          arb_valid;
  logic [1:0]    arb_idx;
  logic          car_g;

  side_rr_arbiter #(.N_SIDE(N_SIDE)) u_arb (
    .car_on (CAR_ON),
    .rr_ptr (rr_ptr),
    .valid  (arb_valid),
    .index  (arb_idx)
  );

`ifdef EMERG_PREEMPT_EN
  logic       em_hold, em_hold_nxt;
  logic       em_main, em_side;
  logic [1:0] em_grant;
`endif

  always_comb begin
    car_g = 1'b0;
    for (int unsigned c = 0; c < N_SIDE; c++) begin
      if (GRANT_IDX == 2'(c)) car_g = CAR_ON[c];
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = GRANT_IDX;
    rr_ptr_nxt = rr_ptr;
    case (state)
      MAIN_GREEN: if (timer >= MG_LAST && arb_valid) begin
        state_nxt = MAIN_YELLOW;
        grant_nxt = arb_idx;
      end
      MAIN_YELLOW: if (timer >= Y_LAST)  state_nxt = ALL_RED_1;
      ALL_RED_1:   if (timer >= AR_LAST) state_nxt = SIDE_GREEN;
      SIDE_GREEN:  if (timer >= SMN_LAST && (!car_g || timer >= SMX_LAST))
        state_nxt = SIDE_YELLOW;
      SIDE_YELLOW: if (timer >= Y_LAST)  state_nxt = ALL_RED_2;
      ALL_RED_2: if (timer >= AR_LAST) begin
        state_nxt  = MAIN_GREEN;
        rr_ptr_nxt = (32'(GRANT_IDX) == N_SIDE - 1) ? 2'd0 : GRANT_IDX + 2'd1;
      end
      default: state_nxt = MAIN_GREEN;
    endcase

`ifdef EMERG_PREEMPT_EN
    // Preemption overlays the normal transitions; yellow phases are never
    // cut short, and a release while held always returns via MAIN_GREEN.
    em_main     = EMERG_REQ && (EMERG_IDX == EMERG_MAIN);
    em_side     = EMERG_REQ && (EMERG_IDX != EMERG_MAIN) && (EMERG_IDX <= 3'(N_SIDE));
    em_grant    = 2'(EMERG_IDX - 3'd1);
    em_hold_nxt = em_hold;
    case (state)
      MAIN_GREEN:
        if (em_side) begin
          state_nxt   = MAIN_YELLOW;
          grant_nxt   = em_grant;
          em_hold_nxt = 1'b1;
        end else if (em_main) begin
          state_nxt = MAIN_GREEN;
          grant_nxt = GRANT_IDX;
        end
      ALL_RED_1:
        if (timer >= AR_LAST) begin
          if (em_side) begin
            grant_nxt   = em_grant;
            em_hold_nxt = 1'b1;
          end else if (em_main || em_hold) begin
            state_nxt   = MAIN_GREEN;
            em_hold_nxt = 1'b0;
          end
        end
      SIDE_GREEN:
        if (em_side && em_grant == GRANT_IDX) begin
          state_nxt   = SIDE_GREEN;
          em_hold_nxt = 1'b1;
        end else if (em_side || em_main || em_hold) begin
          state_nxt = SIDE_YELLOW;
        end
      ALL_RED_2:
        if (timer >= AR_LAST) begin
          if (em_hold) rr_ptr_nxt = rr_ptr;
          if (em_side) begin
            state_nxt   = SIDE_GREEN;
            grant_nxt   = em_grant;
            em_hold_nxt = 1'b1;
          end else begin
            em_hold_nxt = 1'b0;
          end
        end
      default: ;
    endcase
`endif
  end

  always_ff @(posedge CLK or negedge CLEAR) begin
    if (!CLEAR) begin
      state     <= MAIN_GREEN;
      timer     <= '0;
      rr_ptr    <= '0;
      GRANT_IDX <= '0;
      MAIN_SIG  <= GREEN;
      SIDE_SIG  <= '0;
      PHASE     <= 3'd0;
`ifdef EMERG_PREEMPT_EN
      em_hold   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      GRANT_IDX <= grant_nxt;
      if (state_nxt != state)  timer <= '0;
      else if (timer != '1)    timer <= timer + 1'b1;
      MAIN_SIG <= main_lamp(state_nxt);
      for (int unsigned c = 0; c < N_SIDE; c++) begin
        SIDE_SIG[2*c +: 2] <= (grant_nxt == 2'(c)) ? side_lamp(state_nxt) : RED;
      end
      PHASE <= state_nxt;
`ifdef EMERG_PREEMPT_EN
      em_hold <= em_hold_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_road_phase_scheduler.sv
// Scoreboard bench for road_phase_scheduler (N_SIDE=3 defaults).
// Stimulus pushes the expected phase segments (phase, length, grant);
// a negedge monitor splits the DUT's PHASE stream into segments and pops
// one expectation per finished segment. Reset truncates the current
// segment, which is then matched against an "open" (minimum-length) entry.
module tb_road_phase_scheduler;

  logic       CLK = 1'b0;
  logic       CLEAR = 1'b0;
  logic [2:0] CAR_ON = '0;
  logic [1:0] MAIN_SIG;
  logic [5:0] SIDE_SIG;
  logic [1:0] GRANT_IDX;
  logic [2:0] PHASE;
`ifdef EMERG_PREEMPT_EN
  logic       EMERG_REQ = 1'b0;
  logic [2:0] EMERG_IDX = '0;
`endif

  road_phase_scheduler dut (
    .CLK       (CLK),
    .CLEAR     (CLEAR),
    .CAR_ON    (CAR_ON),
`ifdef EMERG_PREEMPT_EN
    .EMERG_REQ (EMERG_REQ),
    .EMERG_IDX (EMERG_IDX),
`endif
    .MAIN_SIG  (MAIN_SIG),
    .SIDE_SIG  (SIDE_SIG),
    .GRANT_IDX (GRANT_IDX),
    .PHASE     (PHASE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] ph;
    int         dur;
    logic [1:0] g;
    bit         open;
  } seg_t;

  seg_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  logic [2:0] cur_ph = '0;
  int         cur_len = 0;
  logic [1:0] seg_main;
  logic [5:0] seg_side;
  logic [1:0] seg_g;
  bit         seg_chg;

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [1:0] exp_main(input logic [2:0] ph);
    case (ph)
      3'd0:    return 2'd2;
      3'd1:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [5:0] exp_side(input logic [2:0] ph, input logic [1:0] g);
    logic [5:0] v;
    v = '0;
    if (ph == 3'd3) v = 6'(2'd2) << (2 * int'(g));
    if (ph == 3'd4) v = 6'(2'd1) << (2 * int'(g));
    return v;
  endfunction

  task automatic push(input logic [2:0] ph, input int dur, input logic [1:0] g, input bit open);
    seg_t e;
    e.ph = ph; e.dur = dur; e.g = g; e.open = open;
    exp_q.push_back(e);
  endtask

  // One full side service: main green, yellow, all-red, side green/yellow/all-red.
  task automatic push_cycle(input int mg, input int sg, input logic [1:0] g);
    push(3'd0, mg, 2'd0, 1'b0);
    push(3'd1, 3, 2'd0, 1'b0);
    push(3'd2, 2, 2'd0, 1'b0);
    push(3'd3, sg, g, 1'b0);
    push(3'd4, 3, g, 1'b0);
    push(3'd5, 2, g, 1'b0);
  endtask

  task automatic end_seg();
    seg_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_segment: phase %0d len %0d, required no segment", cur_ph, cur_len);
    end else begin
      e = exp_q.pop_front();
      chk("seg_phase", int'(cur_ph), int'(e.ph));
      if (e.open) chk("seg_len_min", (cur_len >= e.dur) ? e.dur : cur_len, e.dur);
      else        chk("seg_len", cur_len, e.dur);
      chk("seg_main_sig", int'(seg_main), int'(exp_main(e.ph)));
      chk("seg_side_sig", int'(seg_side), int'(exp_side(e.ph, e.g)));
      if (e.ph >= 3'd3) chk("seg_grant", int'(seg_g), int'(e.g));
      chk("seg_stable", int'(seg_chg), 0);
    end
  endtask

  // Monitor: per-cycle safety checks and segment scoreboard.
  always @(negedge CLK) begin
    int nonred;
    int bad;
    if (!CLEAR) begin
      if (cur_len > 0) end_seg();
      cur_len = 0;
    end else begin
      nonred = (MAIN_SIG != 2'd0) ? 1 : 0;
      bad    = (MAIN_SIG == 2'd3) ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
        if (SIDE_SIG[2*i +: 2] != 2'd0) nonred++;
        if (SIDE_SIG[2*i +: 2] == 2'd3) bad++;
      end
      chk("safety_one_nonred", (nonred <= 1) ? 1 : nonred, 1);
      chk("lamp_code_3", bad, 0);
      if (cur_len > 0 && PHASE != cur_ph) begin
        end_seg();
        cur_len = 0;
      end
      if (cur_len == 0) begin
        cur_ph   = PHASE;
        seg_main = MAIN_SIG;
        seg_side = SIDE_SIG;
        seg_g    = GRANT_IDX;
        seg_chg  = 1'b0;
      end else if (MAIN_SIG != seg_main || SIDE_SIG != seg_side || GRANT_IDX != seg_g) begin
        seg_chg = 1'b1;
      end
      cur_len++;
    end
  end

  // Asynchronous reset must take effect without a clock edge.
  always @(negedge CLEAR) begin
    #1;
    chk("async_rst_main", int'(MAIN_SIG), 2);
    chk("async_rst_side", int'(SIDE_SIG), 0);
    chk("async_rst_phase", int'(PHASE), 0);
  end

  // Drop CLEAR mid-cycle (no clock edge), load sensors, release 1 after a posedge.
  task automatic do_reset(input logic [2:0] car);
    @(posedge CLK);
    #3 CLEAR = 1'b0;
    CAR_ON = car;
    repeat (2) @(posedge CLK);
    #1 CLEAR = 1'b1;
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge CLK);
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    // 1: idle, no cars for 100 cycles -> main green throughout.
    do_reset(3'b000);
    push(3'd0, 100, 2'd0, 1'b1);
    repeat (100) @(posedge CLK);

    // 2: car on approach 1 from release -> max side green.
    do_reset(3'b010);
    push_cycle(16, 10, 2'd1);
    push(3'd0, 16, 2'd0, 1'b0);
    wait_empty(200);
    push(3'd1, 1, 2'd0, 1'b1);

    // 3: all approaches waiting -> grants 0,1,2,0.
    do_reset(3'b111);
    push_cycle(16, 10, 2'd0);
    push_cycle(16, 10, 2'd1);
    push_cycle(16, 10, 2'd2);
    push(3'd0, 16, 2'd0, 1'b0);
    push(3'd1, 3, 2'd0, 1'b0);
    push(3'd2, 2, 2'd0, 1'b0);
    wait_empty(400);
    push(3'd3, 1, 2'd0, 1'b1);

    // 4: one-cycle pulse on approach 2 at main-green cycle 20 -> committed, min side green.
    do_reset(3'b000);
    push_cycle(21, 4, 2'd2);
    repeat (20) @(posedge CLK);
    #1 CAR_ON = 3'b100;
    @(posedge CLK);
    #1 CAR_ON = 3'b000;
    wait_empty(200);
    push(3'd0, 1, 2'd0, 1'b1);

    // 5: reset asserted mid side green.
    do_reset(3'b010);
    push(3'd0, 16, 2'd0, 1'b0);
    push(3'd1, 3, 2'd0, 1'b0);
    push(3'd2, 2, 2'd0, 1'b0);
    push(3'd3, 1, 2'd1, 1'b1);
    begin
      int n;
      n = 0;
      while (PHASE != 3'd3 && n < 100) begin
        @(posedge CLK);
        n++;
      end
      chk("reach_side_green", int'(PHASE), 3);
    end
    repeat (3) @(posedge CLK);
    do_reset(3'b000);
    push(3'd0, 5, 2'd0, 1'b1);
    repeat (5) @(posedge CLK);

`ifdef EMERG_PREEMPT_EN
    // 6: emergency to side approach 2 at main-green cycle 2.
    do_reset(3'b000);
    push(3'd0, 3, 2'd0, 1'b0);
    push(3'd1, 3, 2'd0, 1'b0);
    push(3'd2, 2, 2'd0, 1'b0);
    push(3'd3, 23, 2'd2, 1'b0);
    push(3'd4, 3, 2'd2, 1'b0);
    push(3'd5, 2, 2'd2, 1'b0);
    repeat (2) @(posedge CLK);
    #1 EMERG_IDX = 3'd3;
    EMERG_REQ = 1'b1;
    repeat (28) @(posedge CLK);
    #1 EMERG_REQ = 1'b0;
    wait_empty(200);
    push(3'd0, 1, 2'd0, 1'b1);
`endif

    // Final reset flushes the last open segment.
    do_reset(3'b000);
    wait_empty(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
